// File: rtl/cic3_monitor_scan.sv
// Scan controller for the CIC3 digital monitor mux.
// Steps the monitor select through the enabled taps and waits a fixed settle
// time at each one. It then captures the monitor word and offers it on a
// valid/ready port. Continuous mode rescans until abort; wrap_count counts
// completed passes and saturates.
module cic3_monitor_scan #(
  parameter int MON_W  = 25,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  input  logic [2**SEL_W-1:0]   sel_mask,
  input  logic [MON_W-1:0]      digital_monitor,
  output logic [SEL_W-1:0]      digital_monitor_sel,
  output logic [MON_W-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            wrap_count
);

  localparam int NUM_SEL = 2**SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [MON_W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_sel_q, out_sel_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           wrap_q, wrap_d;
  logic [NUM_SEL-1:0]   mask_q, mask_d;
  logic                 cont_q, cont_d;
  logic                 abort_pend_q, abort_pend_d;

  logic [SEL_W:0]       first_start_s;
  logic [SEL_W:0]       first_latched_s;
  logic [SEL_W:0]       next_latched_s;

  // Lowest set bit of mask at index >= lo; MSB of the result is the found flag.
  function automatic logic [SEL_W:0] find_from(input logic [NUM_SEL-1:0] mask,
                                               input logic [SEL_W:0]     lo);
    logic [SEL_W:0] res;
    res = {1'b0, {SEL_W{1'b0}}};
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) begin
        res = {1'b1, SEL_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Tap searches: first tap of a new mask, first and next tap of the latched mask.
  always_comb begin
    first_start_s   = find_from(sel_mask, {(SEL_W+1){1'b0}});
    first_latched_s = find_from(mask_q, {(SEL_W+1){1'b0}});
    next_latched_s  = find_from(mask_q, {1'b0, sel_q} + (SEL_W+1)'(1));
  end

  // Next-state and output decode; every register holds unless a state acts on it.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    wrap_d       = wrap_q;
    mask_d       = mask_q;
    cont_d       = cont_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      ST_IDLE: begin
        // start beats a same-cycle abort because abort is not looked at here
        if (start) begin
          mask_d       = sel_mask;
          cont_d       = continuous;
          wrap_d       = 8'd0;
          abort_pend_d = 1'b0;
          if (first_start_s[SEL_W]) begin
            sel_d   = first_start_s[SEL_W-1:0];
            cnt_d   = 8'(SETTLE);
            busy_d  = 1'b1;
            state_d = ST_SETTLE;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          out_data_d  = digital_monitor;
          out_sel_d   = sel_q;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // an abort here is remembered so the word on offer is still delivered
        if (abort) begin
          abort_pend_d = 1'b1;
        end else begin
          abort_pend_d = abort_pend_q;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (abort || abort_pend_q) begin
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else if (next_latched_s[SEL_W]) begin
            sel_d   = next_latched_s[SEL_W-1:0];
            cnt_d   = 8'(SETTLE);
            state_d = ST_SETTLE;
          end else if (cont_q) begin
            sel_d   = first_latched_s[SEL_W-1:0];
            cnt_d   = 8'(SETTLE);
            state_d = ST_SETTLE;
            if (wrap_q != 8'hFF) begin
              wrap_d = wrap_q + 8'd1;
            end else begin
              wrap_d = wrap_q;
            end
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      cnt_q        <= 8'd0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 8'd0;
      mask_q       <= '0;
      cont_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      mask_q       <= mask_d;
      cont_q       <= cont_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign digital_monitor_sel = sel_q;
  assign out_data            = out_data_q;
  assign out_sel             = out_sel_q;
  assign out_valid           = out_valid_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign wrap_count          = wrap_q;

endmodule

// File: tb/tb_cic3_monitor_scan.sv
// Scoreboard bench for cic3_monitor_scan: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_cic3_monitor_scan;
  localparam int MON_W  = 25;
  localparam int SEL_W  = 4;
  localparam int SETTLE = 4;
  localparam int WORD_CYC = SETTLE + 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic              abort = 1'b0;
  logic [15:0]       sel_mask = 16'h0;
  logic [MON_W-1:0]  digital_monitor = '0;
  logic [SEL_W-1:0]  digital_monitor_sel;
  logic [MON_W-1:0]  out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;
  logic [7:0]        wrap_count;

  cic3_monitor_scan #(.MON_W(MON_W), .SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .abort(abort), .sel_mask(sel_mask), .digital_monitor(digital_monitor),
    .digital_monitor_sel(digital_monitor_sel), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int hs_count = 0;
  int busy_cycles = 0;
  int done_count = 0;
  logic [SEL_W+MON_W-1:0] exp_q[$];
  logic ready_rand = 1'b0;
  logic ready_val  = 1'b1;

  localparam logic [MON_W-1:0] JUNK = 25'h1555555;

  function automatic logic [MON_W-1:0] mon_val(input logic [SEL_W-1:0] s);
    return {s, 21'h0A5A5 ^ {17'h0, s}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [SEL_W-1:0] s);
    exp_q.push_back({s, mon_val(s)});
  endtask

  // CIC3 monitor model: the tap value only appears once sel has been steady SETTLE+1 cycles
  int age = 0;
  logic [SEL_W-1:0] last_sel = '0;
  always @(negedge clk) begin
    if (digital_monitor_sel != last_sel) age = 0;
    else if (age < 1000) age++;
    last_sel = digital_monitor_sel;
    digital_monitor = (age >= SETTLE + 1) ? mon_val(digital_monitor_sel) : JUNK;
  end

  // Consumer: fixed or random ready, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Monitor: scoreboard pop on handshake, stall stability, sel stability
  logic pv = 1'b0, pr = 1'b0;
  logic [MON_W-1:0] pd = '0;
  logic [SEL_W-1:0] ps = '0, pdsel = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && pv && !pr) begin
        chk("stall_data", 32'(out_data), 32'(pd));
        chk("stall_sel", 32'(out_sel), 32'(ps));
      end
      if (out_valid && pv) chk("mon_sel_held", 32'(digital_monitor_sel), 32'(pdsel));
      if (done && out_valid && !pv) chk("done_with_valid_rise", 32'(done), 32'd0);
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(out_sel), 32'hFFFF);
        end else begin
          logic [SEL_W+MON_W-1:0] e;
          e = exp_q.pop_front();
          chk("word_sel", 32'(out_sel), 32'(e[SEL_W+MON_W-1:MON_W]));
          chk("word_data", 32'(out_data), 32'(e[MON_W-1:0]));
        end
      end
      if (busy) busy_cycles++;
      if (done) done_count++;
    end
    pv = out_valid; pr = out_ready; pd = out_data; ps = out_sel; pdsel = digital_monitor_sel;
  end

  task automatic do_start(input logic [15:0] m, input logic c);
    @(posedge clk); #1;
    start = 1'b1; sel_mask = m; continuous = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int d0;
    bit got;
    #12 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_sel", 32'(digital_monitor_sel), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_valid_busy_done", {29'd0, out_valid, busy, done}, 32'd0);
    chk("rst_wrap", 32'(wrap_count), 32'd0);

    // Full scan, no backpressure
    for (int s = 0; s < 16; s++) push_exp(SEL_W'(s));
    busy_cycles = 0; d0 = done_count;
    do_start(16'hFFFF, 1'b0);
    wait_done("full", 400);
    @(negedge clk);
    chk("full_busy_cycles", 32'(busy_cycles), 32'(16 * WORD_CYC));
    chk("full_done_once", 32'(done_count - d0), 32'd1);
    chk("full_idle", {30'd0, busy, out_valid}, 32'd0);
    chk("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Sparse mask with random backpressure
    ready_rand = 1'b1;
    push_exp(4'd0); push_exp(4'd5); push_exp(4'd10); push_exp(4'd15);
    do_start(16'h8421, 1'b0);
    wait_done("sparse", 2000);
    ready_rand = 1'b0; ready_val = 1'b1;
    @(negedge clk);
    chk("sparse_q_empty", 32'(exp_q.size()), 32'd0);
    chk("sparse_busy", 32'(busy), 32'd0);

    // Empty mask: done one cycle later, never busy
    busy_cycles = 0;
    do_start(16'h0000, 1'b0);
    @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy_valid", {30'd0, busy, out_valid}, 32'd0);
    @(negedge clk);
    chk("empty_done_clear", 32'(done), 32'd0);
    chk("empty_never_busy", 32'(busy_cycles), 32'd0);

    // Abort during SETTLE: done next cycle, no word
    do_start(16'hFFFF, 1'b0);
    pulse_abort();
    @(negedge clk);
    chk("abort_settle_done", 32'(done), 32'd1);
    chk("abort_settle_busy", {30'd0, busy, out_valid}, 32'd0);

    // Continuous 0,1 for 300 passes, then abort with a stalled word
    hs_count = 0;
    for (int p = 0; p < 300; p++) begin push_exp(4'd0); push_exp(4'd1); end
    push_exp(4'd0);
    do_start(16'h0003, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 600 * WORD_CYC + 100 && !got; i++) begin
      @(negedge clk);
      if (hs_count >= 600) got = 1'b1;
    end
    if (!got) chk("cont_timeout", 32'd0, 32'd1);
    ready_val = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid && !out_ready) got = 1'b1;
    end
    if (!got) chk("cont_valid_timeout", 32'd0, 32'd1);
    chk("wrap_sat", 32'(wrap_count), 32'd255);
    pulse_abort();
    repeat (5) @(negedge clk);
    chk("abort_hold_valid", 32'(out_valid), 32'd1);
    chk("abort_hold_busy", 32'(busy), 32'd1);
    ready_val = 1'b1;
    wait_done("cont_abort", 20);
    chk("cont_abort_idle", {30'd0, busy, out_valid}, 32'd0);
    chk("cont_hs_count", 32'(hs_count), 32'd601);
    chk("cont_q_empty", 32'(exp_q.size()), 32'd0);

    // start while busy is ignored
    push_exp(4'd4);
    do_start(16'h0010, 1'b0);
    do_start(16'hFFFF, 1'b1);
    wait_done("ignored_start", 200);
    repeat (2 * WORD_CYC) @(negedge clk);
    chk("ignored_start_q", 32'(exp_q.size()), 32'd0);
    chk("ignored_start_busy", 32'(busy), 32'd0);

    // abort in IDLE does nothing
    d0 = done_count;
    pulse_abort();
    repeat (3) @(negedge clk);
    chk("idle_abort", 32'(done_count - d0), 32'd0);

    // Asynchronous reset mid-SETTLE, then rescan from the lowest tap
    do_start(16'h0C00, 1'b0);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_sel", 32'(digital_monitor_sel), 32'd0);
    chk("arst_flags", {29'd0, busy, out_valid, done}, 32'd0);
    chk("arst_out", {out_sel, out_data}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    push_exp(4'd10); push_exp(4'd11);
    do_start(16'h0C00, 1'b0);
    wait_done("after_rst", 200);
    @(negedge clk);
    chk("after_rst_q", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
